hazard_scheduler: RTL

- Pipeline hazard scheduler for the MIPS core. Sits beside the decoder and generates its has_hazard input.
- Tracks in-flight destination registers in a per-register countdown scoreboard and stalls decode on RAW and WAW conflicts.
- Sequences cache-access waits and taken-branch flushes through a small FSM.
- Drives PC/IF-ID freeze and flush for the rest of the pipeline.

---
 rtl/mips_pkg.sv | 19 +
 rtl/hazard_scheduler_if.sv | 48 ++++
 rtl/reg_scoreboard.sv | 51 +++++
 rtl/hazard_scheduler.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and default constants for the MIPS hazard scheduler slice.
// Optional build macro used by this slice: HAZARD_MEM_TIMEOUT_EN.
package mips_pkg;

   localparam int unsigned DEF_NUM_REGS     = 32;
   localparam int unsigned DEF_REG_ADDR_W   = 5;
   localparam int unsigned DEF_ALU_LAT      = 1;
   localparam int unsigned DEF_LOAD_LAT     = 2;
   localparam int unsigned DEF_FLUSH_CYCLES = 2;
   localparam int unsigned DEF_CNT_W        = 3;
   localparam int unsigned DEF_MEM_TIMEOUT  = 64;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FLUSH    = 2'd2
   } hz_state_t;

endpackage

// File: rtl/hazard_scheduler_if.sv
// Decode-side handshake bundle between the pipeline (master) and the hazard scheduler (slave).
// HAZARD_MEM_TIMEOUT_EN adds the sticky mem_timeout status signal.
interface hazard_scheduler_if
   import mips_pkg::*;
#(
   parameter int unsigned NUM_REGS   = DEF_NUM_REGS,
   parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W
);

   logic                  id_valid;
   logic [REG_ADDR_W-1:0] id_src1;
   logic [REG_ADDR_W-1:0] id_src2;
   logic                  id_src1_valid;
   logic                  id_src2_valid;
   logic [REG_ADDR_W-1:0] id_dst;
   logic                  id_reg_write;
   logic                  id_mem_to_reg;
   logic                  id_cache_en;
   logic                  mem_ready;
   logic                  branch_taken;
   logic                  has_hazard;
   logic                  stall_pc;
   logic                  flush;
   logic [NUM_REGS-1:0]   busy_mask;
   hz_state_t             state;
`ifdef HAZARD_MEM_TIMEOUT_EN
   logic                  mem_timeout;
`endif

   modport master (
      output id_valid, id_src1, id_src2, id_src1_valid, id_src2_valid, id_dst,
             id_reg_write, id_mem_to_reg, id_cache_en, mem_ready, branch_taken,
      input  has_hazard, stall_pc, flush, busy_mask, state
`ifdef HAZARD_MEM_TIMEOUT_EN
      , mem_timeout
`endif
   );

   modport slave (
      input  id_valid, id_src1, id_src2, id_src1_valid, id_src2_valid, id_dst,
             id_reg_write, id_mem_to_reg, id_cache_en, mem_ready, branch_taken,
      output has_hazard, stall_pc, flush, busy_mask, state
`ifdef HAZARD_MEM_TIMEOUT_EN
      , mem_timeout
`endif
   );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register countdown scoreboard: a nonzero count means the result is not yet forwardable.
// Register 0 never holds a count.
module reg_scoreboard
   import mips_pkg::*;
#(
   parameter int unsigned NUM_REGS   = DEF_NUM_REGS,
   parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
   parameter int unsigned CNT_W      = DEF_CNT_W
)(
   input  logic                  clk,
   input  logic                  rst_b,
   input  logic                  wr_en,
   input  logic [REG_ADDR_W-1:0] wr_idx,
   input  logic [CNT_W-1:0]      wr_lat,
   input  logic                  freeze,
   input  logic [REG_ADDR_W-1:0] src1_idx,
   input  logic [REG_ADDR_W-1:0] src2_idx,
   input  logic [REG_ADDR_W-1:0] dst_idx,
   output logic [CNT_W-1:0]      cnt_of_src1,
   output logic [CNT_W-1:0]      cnt_of_src2,
   output logic [CNT_W-1:0]      cnt_of_dst,
   output logic [NUM_REGS-1:0]   busy
);

   logic [CNT_W-1:0] cnt [NUM_REGS];

   // A new write replaces the register's pending decrement in the same cycle.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
      end else begin
         cnt[0] <= '0;
         for (int unsigned r = 1; r < NUM_REGS; r++) begin
            if (wr_en && wr_idx == REG_ADDR_W'(r))
               cnt[r] <= wr_lat;
            else if (!freeze && cnt[r] != '0)
               cnt[r] <= cnt[r] - 1'b1;
         end
      end
   end

   assign cnt_of_src1 = cnt[src1_idx];
   assign cnt_of_src2 = cnt[src2_idx];
   assign cnt_of_dst  = cnt[dst_idx];

   always_comb begin
      busy = '0;
      for (int unsigned r = 0; r < NUM_REGS; r++) busy[r] = (cnt[r] != '0);
   end

endmodule

// File: rtl/hazard_scheduler.sv
// RAW/WAW decode stall, cache-wait and branch-flush sequencing for the MIPS pipeline.
// Define HAZARD_MEM_TIMEOUT_EN to bound MEM_WAIT and expose the sticky mem_timeout flag.
module hazard_scheduler
   import mips_pkg::*;
#(
   parameter int unsigned NUM_REGS     = DEF_NUM_REGS,
   parameter int unsigned REG_ADDR_W   = DEF_REG_ADDR_W,
   parameter int unsigned ALU_LAT      = DEF_ALU_LAT,
   parameter int unsigned LOAD_LAT     = DEF_LOAD_LAT,
   parameter int unsigned FLUSH_CYCLES = DEF_FLUSH_CYCLES,
   parameter int unsigned CNT_W        = DEF_CNT_W
`ifdef HAZARD_MEM_TIMEOUT_EN
   , parameter int unsigned MEM_TIMEOUT = DEF_MEM_TIMEOUT
`endif
)(
   input logic             clk,
   input logic             rst_b,
   hazard_scheduler_if.slave hz
);

   localparam int unsigned   FC_W         = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FC_W-1:0]  FLUSH_RELOAD = FC_W'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] ALU_L        = CNT_W'(ALU_LAT);
   localparam logic [CNT_W-1:0] LOAD_L       = CNT_W'(LOAD_LAT);

   hz_state_t        state_q;
   logic [FC_W-1:0]  flush_cnt;
   logic             pend_flush;
   logic [CNT_W-1:0] cnt_src1, cnt_src2, cnt_dst, new_lat;
   logic             raw, waw, hazard, issue, wr_en, mem_done;

   assign new_lat = hz.id_mem_to_reg ? LOAD_L : ALU_L;

   always_comb begin
      raw = hz.id_valid &
            ((hz.id_src1_valid & (hz.id_src1 != '0) & (cnt_src1 != '0)) |
             (hz.id_src2_valid & (hz.id_src2 != '0) & (cnt_src2 != '0)));
      waw = hz.id_valid & hz.id_reg_write & (hz.id_dst != '0) & (cnt_dst > new_lat);
      hazard = raw | waw | (state_q != RUN);
      issue  = hz.id_valid & (state_q == RUN) & ~hazard & ~hz.branch_taken;
      wr_en  = issue & hz.id_reg_write & (hz.id_dst != '0);
   end

   reg_scoreboard #(
      .NUM_REGS   (NUM_REGS),
      .REG_ADDR_W (REG_ADDR_W),
      .CNT_W      (CNT_W)
   ) u_sb (
      .clk         (clk),
      .rst_b       (rst_b),
      .wr_en       (wr_en),
      .wr_idx      (hz.id_dst),
      .wr_lat      (new_lat),
      .freeze      (state_q == MEM_WAIT),
      .src1_idx    (hz.id_src1),
      .src2_idx    (hz.id_src2),
      .dst_idx     (hz.id_dst),
      .cnt_of_src1 (cnt_src1),
      .cnt_of_src2 (cnt_src2),
      .cnt_of_dst  (cnt_dst),
      .busy        (hz.busy_mask)
   );

`ifdef HAZARD_MEM_TIMEOUT_EN
   localparam int unsigned TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   logic [TMO_W-1:0] tmo_cnt;
   logic             tmo_hit, mem_timeout_q;

   assign tmo_hit = (state_q == MEM_WAIT) & ~hz.mem_ready & (tmo_cnt == TMO_W'(MEM_TIMEOUT - 1));

   // Counts MEM_WAIT cycles without mem_ready; zero whenever not waiting.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         tmo_cnt       <= '0;
         mem_timeout_q <= 1'b0;
      end else if (state_q == MEM_WAIT && !hz.mem_ready) begin
         if (tmo_hit) begin
            tmo_cnt       <= '0;
            mem_timeout_q <= 1'b1;
         end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
      end else begin
         tmo_cnt <= '0;
      end
   end

   assign hz.mem_timeout = mem_timeout_q;
   assign mem_done       = hz.mem_ready | tmo_hit;
`else
   assign mem_done       = hz.mem_ready;
`endif

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q    <= RUN;
         flush_cnt  <= '0;
         pend_flush <= 1'b0;
      end else begin
         unique case (state_q)
            RUN: begin
               if (hz.branch_taken) begin
                  state_q   <= FLUSH;
                  flush_cnt <= FLUSH_RELOAD;
               end else if (issue && hz.id_cache_en) begin
                  state_q <= MEM_WAIT;
               end
            end
            MEM_WAIT: begin
               if (mem_done) begin
                  pend_flush <= 1'b0;
                  if (pend_flush || hz.branch_taken) begin
                     state_q   <= FLUSH;
                     flush_cnt <= FLUSH_RELOAD;
                  end else begin
                     state_q <= RUN;
                  end
               end else if (hz.branch_taken) begin
                  pend_flush <= 1'b1;
               end
            end
            FLUSH: begin
               if (hz.branch_taken)
                  flush_cnt <= FLUSH_RELOAD;
               else if (flush_cnt == '0)
                  state_q <= RUN;
               else
                  flush_cnt <= flush_cnt - 1'b1;
            end
            default: state_q <= RUN;
         endcase
      end
   end

   assign hz.has_hazard = hazard;
   assign hz.stall_pc   = hazard;
   assign hz.flush      = (state_q == FLUSH);
   assign hz.state      = state_q;

endmodule
